// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: conditions the raw PS/2 lines, decodes 11-bit device-to-host
// frames and assembles 3-byte movement packets into saturated signed deltas.
module ps2_mouse_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic              pkt_valid,
  output logic signed [8:0] dx,
  output logic signed [8:0] dy,
  output logic [2:0]        btn,
  output logic              x_ovf,
  output logic              y_ovf,
  output logic              frame_err
);

  localparam int          FW      = $clog2(FILTER_LEN);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [15:0] TO_MAX  = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BITS = 1'b1;

  logic          clk_p0, clk_p1, dat_p0, dat_p1;
  logic          fclk, fclk_d;
  logic [FW-1:0] flt_cnt;
  logic          fall;
  logic [0:0]    state;
  logic [3:0]    bit_idx;
  logic [1:0]    pkt_idx;
  logic [15:0]   to_cnt;
  logic          to_hit;
  logic [8:0]    sr;
  logic [7:0]    b0, b1;
  logic          frame_ok;
  logic          byte_acc;

  // An overflowed axis pins to the full-scale value in the direction of its sign bit.
  function automatic logic signed [8:0] sat9(input logic ovf, input logic sgn,
                                             input logic [7:0] mag);
    if (!ovf)     return signed'({sgn, mag});
    else if (sgn) return 9'sh100;
    else          return 9'sh0FF;
  endfunction

  // Stage p0/p1: two-flop synchronizers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_data;
      dat_p1 <= dat_p0;
    end
  end

  // Stage filter: level changes only after FILTER_LEN agreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fclk    <= 1'b1;
      fclk_d  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      fclk_d <= fclk;
      if (clk_p1 == fclk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_MAX) begin
        fclk    <= clk_p1;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall     = fclk_d & ~fclk;
  assign to_hit   = (to_cnt == TO_MAX);
  assign frame_ok = (^sr) & dat_p1;
  assign byte_acc = fall && (state == ST_BITS) && (bit_idx == 4'd9) && frame_ok;

  // Stage frame: shift register and packet byte storage
  always_ff @(posedge clk) begin
    if (fall && (state == ST_BITS) && (bit_idx != 4'd9)) sr <= {dat_p1, sr[8:1]};
    if (byte_acc && (pkt_idx == 2'd0) && sr[3]) b0 <= sr[7:0];
    if (byte_acc && (pkt_idx == 2'd1)) b1 <= sr[7:0];
  end

  // Stage out: frame FSM, timeout, packet assembly and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      pkt_idx   <= '0;
      to_cnt    <= '0;
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      dx        <= '0;
      dy        <= '0;
      btn       <= '0;
      x_ovf     <= 1'b0;
      y_ovf     <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      if (fall)        to_cnt <= '0;
      else if (!to_hit) to_cnt <= to_cnt + 16'd1;

      case (state)
        ST_IDLE: begin
          if (fall) begin
            if (!dat_p1) begin
              state   <= ST_BITS;
              bit_idx <= '0;
            end
          end else if (to_hit && (pkt_idx != 2'd0)) begin
            pkt_idx <= '0;
          end
        end
        default: begin
          if (fall) begin
            if (bit_idx == 4'd9) begin
              state <= ST_IDLE;
              if (frame_ok) begin
                case (pkt_idx)
                  2'd0: if (sr[3]) pkt_idx <= 2'd1;
                  2'd1: pkt_idx <= 2'd2;
                  2'd2: begin
                    pkt_idx   <= 2'd0;
                    pkt_valid <= 1'b1;
                    btn       <= b0[2:0];
                    x_ovf     <= b0[6];
                    y_ovf     <= b0[7];
                    dx        <= sat9(b0[6], b0[4], b1);
                    dy        <= sat9(b0[7], b0[5], sr[7:0]);
                  end
                  default: pkt_idx <= 2'd0;
                endcase
              end else begin
                frame_err <= 1'b1;
                pkt_idx   <= 2'd0;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else if (to_hit) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
            pkt_idx   <= 2'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ps2_mouse_rx.md
# ps2_mouse_rx

Receives PS/2 device-to-host frames from a mouse and assembles validated 3-byte movement packets. It outputs a single-cycle packet strobe with signed 9-bit deltas and button state. It sits directly upstream of the VGA cursor/pixel stage, which consumes `pkt_valid`, `dx`, `dy` and `btn` to move and draw the cursor. Raw `ps2_clk`/`ps2_data` come from `uio_in[0]`/`uio_in[1]`. The block is receive-only and never drives the PS/2 lines.

## Interface
Parameters:
- `FILTER_LEN`, 4: consecutive identical synchronized samples required to change the filtered PS/2 clock level (≥2).
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles without a PS/2 falling edge before abort (~2 ms at 25.175 MHz). Counter is 16 bits wide.

Ports:
- `clk` in 1: system clock, 25.175 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data, asynchronous to `clk`.
- `pkt_valid` out 1: one-cycle strobe; a new packet is on `dx`/`dy`/`btn`/`*_ovf`.
- `dx` out 9: X movement, two's complement, positive means right.
- `dy` out 9: Y movement, two's complement, positive means up (raw PS/2 sense).
- `btn` out 3: {middle, right, left}.
- `x_ovf` out 1: X overflow flag from byte 0.
- `y_ovf` out 1: Y overflow flag from byte 0.
- `frame_err` out 1: one-cycle strobe on a parity, stop-bit or mid-frame timeout error.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - Filtered clock `fclk` (reset 1) takes a new level only after `FILTER_LEN` consecutive synchronized samples at that level.
  - `fall` is a one-cycle internal strobe when `fclk` goes 1→0. The synchronized data is sampled in the same cycle.
- Frame FSM, states IDLE and BITS:
  - IDLE: on `fall` with data=0 (start bit), go to BITS with bit index 0. On `fall` with data=1, stay in IDLE and discard the edge.
  - BITS: on each `fall`, capture data at the current index, then increment the index.
    - Indices 0–7 are data, LSB first.
    - Index 8 is the parity bit.
    - Index 9 is the stop bit.
  - At index 9, return to IDLE and check the frame:
    - Good frame: the XOR of the 8 data bits and the parity bit equals 1 (odd parity), and stop = 1. A byte is accepted.
    - Bad frame: pulse `frame_err`, discard the byte, reset the packet index to 0.
- Timeout:
  - A counter clears on every `fall` and saturates at `TIMEOUT_CYCLES-1`.
  - Reaching `TIMEOUT_CYCLES-1` in BITS: go to IDLE, pulse `frame_err`, reset the packet index to 0.
  - Reaching `TIMEOUT_CYCLES-1` in IDLE with packet index ≠ 0: reset the packet index to 0 with no `frame_err`.
- Packet assembly, index 0..2:
  - Index 0: an accepted byte is stored only if bit3 = 1, and the index advances. If bit3 = 0, the byte is discarded, the index stays 0, and there is no error (resync).
  - Index 1: store the byte, advance.
  - Index 2: publish the packet, index returns to 0.
- Publishing, using b0/b1/b2:
  - `btn` = b0[2:0].
  - `x_ovf` = b0[6], `y_ovf` = b0[7].
  - `dx` = {b0[4], b1}. If `x_ovf`=1, `dx` saturates instead: 9'h0FF (+255) when b0[4]=0, 9'h100 (−256) when b0[4]=1.
  - `dy` = {b0[5], b2}, with identical saturation using `y_ovf` and b0[5].
- Output holding:
  - `dx`/`dy`/`btn`/`*_ovf` hold their last published values until the next `pkt_valid`.
  - Erroring bytes never alter them.

## Timing
- Reset:
  - All outputs 0.
  - FSM in IDLE, packet index 0, timeout counter 0, `fclk` and synchronizer flops at 1.
- Reset asserted mid-frame or mid-packet: everything returns to reset state immediately, and the partial frame/packet is lost.
- Edge latency: if raw `ps2_clk` is first sampled low at edge k and stays low, `fall` is high in the cycle after edge k+1+`FILTER_LEN`.
- Glitches: any low pulse shorter than `FILTER_LEN` `clk` cycles (after synchronization) produces no `fall`.
- Output latency:
  - `pkt_valid`, `frame_err` and the published outputs are registered.
  - Each is asserted exactly one cycle after the `fall` cycle carrying the stop bit (or the cycle the timeout is reached).
  - Each strobe is high for exactly 1 cycle.
- Exclusivity: `pkt_valid` and `frame_err` are never high in the same cycle.
- Priority: if `fall` and timeout coincide, `fall` wins; the counter clears and there is no abort.
- Downstream contract: there is no backpressure. The consumer must sample on `pkt_valid`. The minimum spacing between strobes is one full PS/2 byte (>500 `clk` cycles at real PS/2 rates).

## Test plan
- Bytes 0x28, 0x05, 0xFB with correct odd parity at 12.5 kHz PS/2 clock → one `pkt_valid`; `dx`=9'h005, `dy`=9'h1FB, `btn`=0, `x_ovf`=`y_ovf`=0, `frame_err` never high.
- Byte 0x09 then 0x00, 0x00 → `btn`=3'b001, `dx`=`dy`=0. Then 0xC8, 0x10, 0x20 → `dx`=9'h0FF, `dy`=9'h0FF, `x_ovf`=`y_ovf`=1.
- Byte 0x28 sent with wrong parity, then 0x05 → `frame_err` 1 cycle after the stop edge, no `pkt_valid`. Then send 0x08, 0x01, 0x02 → `pkt_valid` with `dx`=1, `dy`=2.
- Leading stray byte 0x05 (bit3=0) followed by 0x08, 0x03, 0x04 → exactly one `pkt_valid`, `dx`=3, `dy`=4, no `frame_err`.
- Stop PS/2 clock after 4 bits of a frame for >`TIMEOUT_CYCLES` → one `frame_err`. Next full 3-byte packet decodes correctly.
- Inject 2-cycle low glitches on `ps2_clk` between real edges, and assert `rst_n` low mid-packet → glitches ignored and the packet still decodes. After reset release, all outputs are 0 and the next full packet decodes.
